fb_arbiter: RTL

FB_ARBITER -- requirements
Module: fb_arbiter

---
 rtl/fb_pkg.sv | 10 +
 rtl/fb_read_pipe.sv | 23 ++
 rtl/fb_arbiter.sv | 92 +++++++++
 3 files changed

// File: rtl/fb_pkg.sv
// fb_pkg: framebuffer defaults, arbiter state type and saturating counter helper
package fb_pkg;
  localparam int FB_WIDTH = 400;
  localparam int FB_HEIGHT = 300;
  localparam int PIXEL_W = 16;
  typedef enum logic [1:0] {IDLE, RENDER, DONE} fb_state_t;
  function automatic logic [15:0] sat_inc(input logic [15:0] v, input logic en);
    return (en && v != 16'hFFFF) ? v + 16'd1 : v;
  endfunction
endpackage

// File: rtl/fb_read_pipe.sv
// fb_read_pipe: delay line carrying read-valid and out-of-range flags to the data return cycle
module fb_read_pipe #(
  parameter int DEPTH = 3
) (
  input logic clk,
  input logic rst,
  input logic req,
  input logic oor,
  output logic valid,
  output logic oor_out
);
  logic [DEPTH-1:0] v, o;
  always_ff @(posedge clk)
    if (rst) begin
      v <= '0;
      o <= '0;
    end else begin
      v <= DEPTH'({v, req});
      o <= DEPTH'({o, oor});
    end
  assign valid = v[DEPTH-1];
  assign oor_out = o[DEPTH-1];
endmodule

// File: rtl/fb_arbiter.sv
// fb_arbiter: double-buffered framebuffer arbiter with read-priority BRAM port; FB_ARB_STATS_EN adds drop/stall counters
module fb_arbiter #(
  parameter int WIDTH = fb_pkg::FB_WIDTH,
  parameter int HEIGHT = fb_pkg::FB_HEIGHT,
  parameter int PIXEL_W = fb_pkg::PIXEL_W,
  parameter int MEM_LATENCY = 2,
  localparam int AW = $clog2(WIDTH * HEIGHT)
) (
  input logic clk_pixel_in,
  input logic rst_in,
  input logic nf_in,
  input logic rd_req_in,
  input logic [AW-1:0] rd_addr_in,
  output logic rd_valid_out,
  output logic [PIXEL_W-1:0] rd_data_out,
  input logic wr_valid_in,
  output logic wr_ready_out,
  input logic [AW-1:0] wr_addr_in,
  input logic [PIXEL_W-1:0] wr_data_in,
  input logic frame_done_in,
  output logic render_start_out,
  output logic [AW:0] mem_addr_out,
  output logic mem_we_out,
  output logic [PIXEL_W-1:0] mem_din_out,
  input logic [PIXEL_W-1:0] mem_dout_in,
`ifdef FB_ARB_STATS_EN
  output logic [15:0] dropped_frames_out,
  output logic [15:0] write_stalls_out,
`endif
  output logic display_buf_out
);
  import fb_pkg::*;
  localparam int N = WIDTH * HEIGHT;
  fb_state_t state, state_nxt;
  logic start, swap, wr_fire, rd_oor, wr_oor, pipe_valid, pipe_oor;
  assign rd_oor = {1'b0, rd_addr_in} >= (AW + 1)'(N);
  assign wr_oor = {1'b0, wr_addr_in} >= (AW + 1)'(N);
  assign wr_ready_out = !rd_req_in && state == RENDER;
  assign wr_fire = wr_valid_in && wr_ready_out;
  always_comb begin
    start = nf_in && (state != RENDER || frame_done_in);
    swap = start && state != IDLE;
    state_nxt = start ? RENDER : (state == RENDER && frame_done_in) ? DONE : state;
  end
  always_ff @(posedge clk_pixel_in)
    if (rst_in) begin
      state <= IDLE;
      display_buf_out <= 1'b0;
      render_start_out <= 1'b0;
    end else begin
      state <= state_nxt;
      display_buf_out <= display_buf_out ^ swap;
      render_start_out <= start;
    end
  always_ff @(posedge clk_pixel_in)
    if (rst_in) begin
      mem_addr_out <= '0;
      mem_we_out <= 1'b0;
      mem_din_out <= '0;
    end else if (rd_req_in) begin
      mem_we_out <= 1'b0;
      if (!rd_oor) mem_addr_out <= {display_buf_out, rd_addr_in};
    end else if (wr_fire) begin
      mem_addr_out <= {!display_buf_out, wr_addr_in};
      mem_we_out <= !wr_oor;
      mem_din_out <= wr_data_in;
    end else begin
      mem_we_out <= 1'b0;
    end
  fb_read_pipe #(.DEPTH(1 + MEM_LATENCY)) u_pipe (
    .clk(clk_pixel_in),
    .rst(rst_in),
    .req(rd_req_in),
    .oor(rd_req_in && rd_oor),
    .valid(pipe_valid),
    .oor_out(pipe_oor)
  );
  assign rd_valid_out = pipe_valid;
  assign rd_data_out = (pipe_valid && !pipe_oor) ? mem_dout_in : '0;
`ifdef FB_ARB_STATS_EN
  logic drop;
  assign drop = nf_in && !frame_done_in && state == RENDER;
  always_ff @(posedge clk_pixel_in)
    if (rst_in) begin
      dropped_frames_out <= '0;
      write_stalls_out <= '0;
    end else begin
      dropped_frames_out <= sat_inc(dropped_frames_out, drop);
      write_stalls_out <= sat_inc(write_stalls_out, wr_valid_in && !wr_ready_out);
    end
`endif
endmodule
